tweak_seq_ctrl: RTL
===================

// Module: tweak_seq_ctrl
// PURPOSE
//  Instruction sequencer for the tozPU core; replaces the ad-hoc clk_h1..h4/phase_A..D generation.
//  Single-clock FSM: steps FETCH (ROM) -> LOAD (register file read) -> EXEC (ALU latch) -> STORE (register write, PC advance).
//  Owns the program counter, holds the fetched instruction word, and emits one-cycle strobes to regs/ALU.
// PARAMETERS
//  ADDR_W    4      ROM address / PC width; PC wraps modulo 2**ADDR_W
//  RESET_PC  0      PC value after reset
//  HALT_OP   8'h3F  opcode[31:24] value that halts the sequencer (format 00, instr 6'h3F)
// PORTS
//  CLK          in   1       system clock, all state on posedge
//  NRES         in   1       asynchronous reset, active-low
//  run          in   1       level; 1 = execute instructions, 0 = stop at next instruction boundary
//  rom_rd       out  1       ROM read request; held high for the whole FETCH state
//  rom_addr     out  ADDR_W  ROM address (= pc)
//  rom_ack      in   1       ROM data valid; sampled only in FETCH
//  rom_data     in   32      instruction word
//  opcode_q     out  32      registered instruction word, drives tweak_decoder
//  reg_l_trig   out  1       one-cycle register-file load strobe
//  alu_latch    out  1       one-cycle strobe: capture ALU result
//  reg_s_trig   out  1       one-cycle register-file store strobe
//  pc           out  ADDR_W  program counter
//  busy         out  1       1 in any state except IDLE and HALT
//  halted       out  1       1 in HALT
//  retired      out  16      instructions completed (STORE states passed), wraps at 16'hFFFF
// BEHAVIOUR
//  Reset (NRES=0, async): state=IDLE, pc=RESET_PC, opcode_q=0, retired=0, all strobes/rom_rd/busy/halted=0.
//  States: IDLE, FETCH, LOAD, EXEC, STORE, HALT (one-hot or binary, implementer's choice).
//  IDLE : run=1 -> FETCH next cycle; else stay.
//  FETCH: rom_rd=1, rom_addr=pc. Waits indefinitely while rom_ack=0 (no timeout).
//         rom_ack=1: opcode_q<=rom_data; if rom_data[31:24]==HALT_OP -> HALT, else -> LOAD.
//  LOAD : reg_l_trig=1 for this cycle -> EXEC.
//  EXEC : alu_latch=1 for this cycle -> STORE.
//  STORE: reg_s_trig=1 iff opcode_q[31:30]!=2'b00 (0-operand formats never write);
//         pc<=pc+1 (wrap 2**ADDR_W-1 -> 0); retired<=retired+1;
//         next: run=1 -> FETCH, run=0 -> IDLE.
//  HALT : sticky; only NRES leaves it. pc stays at the halt instruction's address; no strobes.
//  Latency: with rom_ack in first FETCH cycle, 4 cycles/instruction; each extra ack-wait cycle adds 1.
//  run falling mid-instruction: current instruction completes through STORE, then IDLE. run ignored in LOAD/EXEC.
//  Strobes are mutually exclusive and registered-state decoded (glitch-free, never two in one cycle).
//  rom_ack outside FETCH: ignored. rom_data sampled only on the FETCH+ack cycle.
//  Reset mid-operation: immediate return to reset values; partial instruction discarded, no store.
// CONFIGURATION
//  TWEAK_SEQ_SINGLESTEP_EN defined: extra input port `step` (1 bit). IDLE->FETCH requires run=1 AND
//    a step rising edge (registered edge detect); STORE always returns to IDLE, so exactly one
//    instruction per step pulse. Step edges outside IDLE are discarded.
//  Not defined: no `step` port; behaviour exactly as above.
// TESTING
//  1. NRES=0 then 1, run=0 for 10 cycles -> pc=0, busy=0, all strobes 0, retired=0.
//  2. run=1, rom_ack tied 1, ROM = 8 words of 0x80000012 -> strobes L,A,S every 4 cycles, pc 0..7, retired=8 after 32 cycles.
//  3. rom_ack delayed 3 cycles per fetch -> 7 cycles/instruction, opcode_q only changes on ack cycle.
//  4. ROM[2]=0x3F000000 -> after 2 retires, halted=1, pc=2, no further rom_rd; stays until NRES.
//  5. ADDR_W=4, 17 instructions of 0x00000004 -> pc wraps 15->0->1, reg_s_trig never asserted.
//  6. Drop run during EXEC -> STORE completes, then IDLE; assert NRES during LOAD -> pc=0, no reg_s_trig.

Source files
------------

// File: rtl/tweak_seq_ctrl.sv
// tweak_seq_ctrl: instruction sequencer for the tozPU core.
// Steps FETCH -> LOAD -> EXEC -> STORE, owns the PC, holds the fetched word and
// emits one-cycle strobes to the register file and ALU.
// Optional feature macro: TWEAK_SEQ_SINGLESTEP_EN adds a `step` input; each step
// rising edge seen in IDLE (with run=1) executes exactly one instruction.

module tweak_seq_ctrl #(
    parameter int unsigned       ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]        HALT_OP  = 8'h3F
) (
    input  logic              CLK,
    input  logic              NRES,
    input  logic              run,
`ifdef TWEAK_SEQ_SINGLESTEP_EN
    input  logic              step,
`endif
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [31:0]       rom_data,
    output logic [31:0]       opcode_q,
    output logic              reg_l_trig,
    output logic              alu_latch,
    output logic              reg_s_trig,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StExec,
        StStore,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       opcode_d;
    logic [15:0]       retired_q, retired_d;

    // Conditions to leave IDLE and the state that follows STORE.
    logic   start_ok;
    state_e store_next;

`ifdef TWEAK_SEQ_SINGLESTEP_EN
    logic step_q;
    logic step_rise;

    // Registered copy of step for rising-edge detection.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // One instruction per step edge; edges seen outside IDLE are simply lost.
    always_comb begin
        step_rise  = step & ~step_q;
        start_ok   = run & step_rise;
        store_next = StIdle;
    end
`else
    // Free-running mode: run alone gates instruction issue.
    always_comb begin
        start_ok   = run;
        store_next = run ? StFetch : StIdle;
    end
`endif

    // State, PC, instruction word and retire counter registers.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            opcode_q  <= 32'h0;
            retired_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; rom_data is only captured on the FETCH cycle with ack.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (rom_ack) begin
                    opcode_d = rom_data;
                    state_d  = (rom_data[31:24] == HALT_OP) ? StHalt : StLoad;
                end
            end
            StLoad: begin
                state_d = StExec;
            end
            StExec: begin
                state_d = StStore;
            end
            StStore: begin
                pc_d      = pc_q + ADDR_W'(1);
                retired_d = retired_q + 16'd1;
                state_d   = store_next;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the registered state only, so strobes are exclusive.
    always_comb begin
        rom_rd     = 1'b0;
        reg_l_trig = 1'b0;
        alu_latch  = 1'b0;
        reg_s_trig = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            StFetch: begin
                rom_rd = 1'b1;
                busy   = 1'b1;
            end
            StLoad: begin
                reg_l_trig = 1'b1;
                busy       = 1'b1;
            end
            StExec: begin
                alu_latch = 1'b1;
                busy      = 1'b1;
            end
            StStore: begin
                // Format 00 instructions have no destination operand.
                reg_s_trig = (opcode_q[31:30] != 2'b00);
                busy       = 1'b1;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign retired  = retired_q;

endmodule
